// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX mispredict redirects, D-mem waits.
// Outputs are combinational from state and inputs. Perf counters exist only with PIPE_PERF_CNT_EN defined.
module pipe_hazard_ctrl #(
    parameter int RF_ADDR_W        = 5,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [RF_ADDR_W-1:0] i_rs1_addr_ID,
    input  logic [RF_ADDR_W-1:0] i_rs2_addr_ID,
    input  logic                 i_rs1_used_ID,
    input  logic                 i_rs2_used_ID,
    input  logic [RF_ADDR_W-1:0] i_rd_addr_EX,
    input  logic                 i_mem_rd_EX,
    input  logic                 i_mispred_EX,
    input  logic                 i_dmem_busy,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_en,
    output logic                 o_id_ex_flush,
    output logic                 o_ex_mem_en,
    output logic [1:0]           o_state,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic [CNT_W-1:0]     o_flush_events
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEMWAIT  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] RB = 3'(REDIRECT_BUBBLES);

    state_t     state_q, state_d;
    logic [2:0] rcnt_q, rcnt_d;

    logic load_use;
    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c, ex_mem_en_c;

    assign load_use = i_mem_rd_EX && (i_rd_addr_EX != '0) &&
                      ((i_rs1_used_ID && (i_rs1_addr_ID == i_rd_addr_EX)) ||
                       (i_rs2_used_ID && (i_rs2_addr_ID == i_rd_addr_EX)));

    always_comb begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_en_c    = 1'b1;
        id_ex_flush_c = 1'b0;
        ex_mem_en_c   = 1'b1;
        state_d       = state_q;
        rcnt_d        = rcnt_q;

        if (i_dmem_busy) begin
            // Freeze everything; a REDIRECT in progress keeps its place and count.
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            if (state_q == S_RUN) begin
                state_d = S_MEMWAIT;
            end
        end else if (i_mispred_EX) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (RB != 3'd0) begin
                state_d = S_REDIRECT;
                rcnt_d  = RB;
            end else begin
                state_d = S_RUN;
            end
        end else if (state_q == S_REDIRECT) begin
            // Discard the stale fetch returning from I-mem; load-use is moot behind a flush.
            if_id_flush_c = 1'b1;
            rcnt_d        = rcnt_q - 3'd1;
            if (rcnt_q <= 3'd1) begin
                state_d = S_RUN;
            end
        end else begin
            state_d = S_RUN;
            if (load_use) begin
                pc_en_c       = 1'b0;
                if_id_en_c    = 1'b0;
                id_ex_flush_c = 1'b1;
            end
        end
    end

    // Held in reset the pipeline free-runs with no flushes.
    assign o_pc_en       = ~i_rst_n | pc_en_c;
    assign o_if_id_en    = ~i_rst_n | if_id_en_c;
    assign o_if_id_flush =  i_rst_n & if_id_flush_c;
    assign o_id_ex_en    = ~i_rst_n | id_ex_en_c;
    assign o_id_ex_flush =  i_rst_n & id_ex_flush_c;
    assign o_ex_mem_en   = ~i_rst_n | ex_mem_en_c;
    assign o_state       = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_RUN;
            rcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mispred_acc;

    assign mispred_acc = i_mispred_EX & ~i_dmem_busy;

    // Both counters saturate at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (mispred_acc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_events = flush_cnt_q;
`else
    assign o_stall_cycles = '0;
    assign o_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2, CNT_W=4).
// Reference model tracks "bubbles still owed" and "frozen on memory" rather than FSM encoding.
module tb_pipe_hazard_ctrl;

    localparam int RB   = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mem_rd, mispred, busy;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles, flush_events;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state
    int bubbles = 0;
    bit waiting = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .RF_ADDR_W       (5),
        .REDIRECT_BUBBLES(RB),
        .CNT_W           (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rs1_addr_ID (rs1),
        .i_rs2_addr_ID (rs2),
        .i_rs1_used_ID (u1),
        .i_rs2_used_ID (u2),
        .i_rd_addr_EX  (rd),
        .i_mem_rd_EX   (mem_rd),
        .i_mispred_EX  (mispred),
        .i_dmem_busy   (busy),
        .o_pc_en       (pc_en),
        .o_if_id_en    (if_id_en),
        .o_if_id_flush (if_id_flush),
        .o_id_ex_en    (id_ex_en),
        .o_id_ex_flush (id_ex_flush),
        .o_ex_mem_en   (ex_mem_en),
        .o_state       (state),
        .o_stall_cycles(stall_cycles),
        .o_flush_events(flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic b1, input logic b2,
                         input logic [4:0] d, input logic mr, input logic mp, input logic bz);
        rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d; mem_rd = mr; mispred = mp; busy = bz;
    endtask

    // Called just after a rising edge with inputs already applied; returns just after the next one.
    task automatic run_cycle();
        logic [5:0] exp_v;
        logic [1:0] exp_s;
        bit         lu;
        if (!rst_n) begin
            bubbles = 0; waiting = 1'b0; m_stall = 0; m_flush = 0;
        end
        lu = mem_rd && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
        if (!rst_n)          exp_v = 6'b110101;
        else if (busy)       exp_v = 6'b000000;
        else if (mispred)    exp_v = 6'b111111;
        else if (bubbles > 0) exp_v = 6'b111101;
        else if (lu)         exp_v = 6'b000111;
        else                 exp_v = 6'b110101;
        exp_s = (bubbles > 0) ? 2'd2 : (waiting ? 2'd1 : 2'd0);

        @(negedge clk);
        chk("ctl", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en},
            {26'd0, exp_v});
        chk("state", {30'd0, state}, {30'd0, exp_s});
        chk("stall_cnt", {28'd0, stall_cycles}, PERF ? m_stall : 0);
        chk("flush_cnt", {28'd0, flush_events}, PERF ? m_flush : 0);

        if (rst_n) begin
            if (!exp_v[5] && m_stall < CMAX) m_stall++;
            if (mispred && !busy && m_flush < CMAX) m_flush++;
            if (busy) begin
                if (bubbles == 0) waiting = 1'b1;
            end else if (mispred) begin
                bubbles = RB; waiting = 1'b0;
            end else begin
                if (bubbles > 0) bubbles--;
                waiting = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        rst_n = 1'b1;
        run_cycle();

        // Load-use on rs1, one bubble then EX holds the bubble
        drive(5, 0, 1, 0, 5, 1, 0, 0); run_cycle();
        drive(5, 0, 1, 0, 5, 0, 0, 0); run_cycle();
        drive(0, 7, 0, 1, 7, 1, 0, 0); run_cycle();
        // rd=0 never stalls; unused rs2 match never stalls
        drive(0, 5, 1, 0, 0, 1, 0, 0); run_cycle();
        drive(3, 5, 1, 0, 5, 1, 0, 0); run_cycle();

        // Mispredict then two redirect bubbles with a hazard pattern present (ignored)
        drive(0, 0, 0, 0, 0, 0, 1, 0); run_cycle();
        drive(5, 0, 1, 0, 5, 1, 0, 0); run_cycle();
        drive(5, 0, 1, 0, 5, 1, 0, 0); run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();

        // Mispredict frozen behind a memory wait, acted on when it clears
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1); run_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0); run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
        end

        // Reset landing mid-REDIRECT (rcnt=2)
        drive(0, 0, 0, 0, 0, 0, 1, 0); run_cycle();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();

        // Random traffic with narrow register range to provoke hazards
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 2));
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
